// File: rtl/axi_loader_pkg.sv
// Shared types and helpers for the AXI parameter burst loader.
//   state_t        - loader FSM states
//   AXI_BURST_INCR - ARBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  - RRESP value for a good beat
//   ceil_beats     - beats needed to carry a given element count
//   beats_to_page  - beats that fit before the next 4 KB boundary
package axi_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_AR,
    ST_W_R,
    ST_B_AR,
    ST_B_R,
    ST_FIN
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned PAGE_BYTES     = 4096;

  // Number of beats of `lanes` elements each needed to carry `count` elements.
  function automatic logic [31:0] ceil_beats(input logic [31:0] count,
                                             input int unsigned lanes);
    return (count + 32'(lanes) - 32'd1) / 32'(lanes);
  endfunction

  // Beats of `bytes` each that still fit in the current 4 KB page.
  function automatic logic [31:0] beats_to_page(input logic [11:0] page_off,
                                                input int unsigned bytes);
    return (32'(PAGE_BYTES) - 32'(page_off)) / 32'(bytes);
  endfunction

endpackage

// File: rtl/axi_rd_burst_gen.sv
// AR sequence generator for one section (weights or biases).
//   clk, rst : clock, asynchronous active-high reset
//   arm      : load a new section (base, total)
//   base     : first byte address of the section, BYTES-aligned
//   total    : beats to request for the section
//   issue    : AR handshake of the burst currently offered
//   addr     : ARADDR of the burst currently offered
//   len      : ARLEN of the burst currently offered
//   more     : beats of the section not yet requested
module axi_rd_burst_gen
  import axi_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BYTES     = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  total,
  input  logic              issue,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        len,
  output logic              more
);

  logic [CNT_W-1:0] remaining;
  logic [31:0]      page_beats;
  logic [31:0]      burst_beats;

  // Burst length is the smallest of the burst cap, what is left, and what
  // fits before the 4 KB boundary. Depends only on registered state, so it
  // stays stable while ARVALID waits for ARREADY.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    burst_beats = 32'(MAX_BURST);
    page_beats  = beats_to_page(addr[11:0], BYTES);
    if (32'(remaining) < burst_beats) burst_beats = 32'(remaining);
    if (page_beats < burst_beats)     burst_beats = page_beats;
  end

  assign len  = 8'(burst_beats - 32'd1);
  assign more = (remaining != '0);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (arm) begin
      addr      <= base;
      remaining <= total;
    end else if (issue) begin
      addr      <= addr + ADDR_W'(burst_beats * BYTES);
      remaining <= remaining - CNT_W'(burst_beats);
    end
  end

endmodule

// File: rtl/axi_param_burst_loader.sv
// Fetches a layer's weight tensor and then its bias vector over AXI4 INCR
// bursts and streams the unpacked beats to the parameter RAMs.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle request, sampled only in IDLE
//   w_base/w_count      : weight base byte address / element count
//   b_base/b_count      : bias base byte address / element count
//   busy, done, err     : status; err is sticky until the next start
//   M_AXI_AR*           : read address channel (master side)
//   M_AXI_R*            : read data channel (master side)
//   wr_en/sel/addr/data/mask : element write port (sel 0 = weight, 1 = bias)
module axi_param_burst_loader
  import axi_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ELEM_W    = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          w_base,
  input  logic [CNT_W-1:0]           w_count,
  input  logic [ADDR_W-1:0]          b_base,
  input  logic [CNT_W-1:0]           b_count,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  output logic [ADDR_W-1:0]          M_AXI_ARADDR,
  output logic [7:0]                 M_AXI_ARLEN,
  output logic [2:0]                 M_AXI_ARSIZE,
  output logic [1:0]                 M_AXI_ARBURST,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY,
  input  logic [DATA_W-1:0]          M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RLAST,
  output logic                       wr_en,
  output logic                       wr_sel,
  output logic [CNT_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W/ELEM_W-1:0]   wr_mask
);

  localparam int unsigned LANES   = DATA_W / ELEM_W;
  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned SIZE_L2 = $clog2(BYTES);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  w_count_q, b_count_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [CNT_W-1:0]  elem_cnt;   // elements received so far in this section
  logic              drain;      // error seen: swallow the rest of the burst

  logic              in_r, beat, beat_err, issue;
  logic              arm;
  logic [ADDR_W-1:0] arm_base;
  logic [CNT_W-1:0]  arm_beats;
  logic [ADDR_W-1:0] gen_addr;
  logic [7:0]        gen_len;
  logic              gen_more;
  logic [CNT_W-1:0]  sec_count;

  assign in_r     = (state == ST_W_R) || (state == ST_B_R);
  assign beat     = in_r && M_AXI_RVALID;
  assign beat_err = beat && (M_AXI_RRESP != AXI_RESP_OKAY);
  assign issue    = M_AXI_ARVALID && M_AXI_ARREADY;

  // Next state plus re-arming of the burst generator at section starts.
  // A section is armed straight from the inputs in IDLE and from the latched
  // copies when moving from weights to biases.
  always_comb begin
    state_nx  = state;
    arm       = 1'b0;
    arm_base  = w_base;
    arm_beats = CNT_W'(ceil_beats(32'(w_count), LANES));
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (w_count != '0) begin
            state_nx = ST_W_AR;
            arm      = 1'b1;
          end else if (b_count != '0) begin
            state_nx  = ST_B_AR;
            arm       = 1'b1;
            arm_base  = b_base;
            arm_beats = CNT_W'(ceil_beats(32'(b_count), LANES));
          end else begin
            state_nx = ST_FIN;
          end
        end
      end
      ST_W_AR: if (M_AXI_ARREADY) state_nx = ST_W_R;
      ST_W_R: begin
        if (beat && M_AXI_RLAST) begin
          if (drain || beat_err) begin
            state_nx = ST_FIN;
          end else if (gen_more) begin
            state_nx = ST_W_AR;
          end else if (b_count_q != '0) begin
            state_nx  = ST_B_AR;
            arm       = 1'b1;
            arm_base  = b_base_q;
            arm_beats = CNT_W'(ceil_beats(32'(b_count_q), LANES));
          end else begin
            state_nx = ST_FIN;
          end
        end
      end
      ST_B_AR: if (M_AXI_ARREADY) state_nx = ST_B_R;
      ST_B_R: begin
        if (beat && M_AXI_RLAST) begin
          if (!drain && !beat_err && gen_more) state_nx = ST_B_AR;
          else                                 state_nx = ST_FIN;
        end
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      w_count_q <= '0;
      b_count_q <= '0;
      b_base_q  <= '0;
      elem_cnt  <= '0;
      err       <= 1'b0;
      drain     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        w_count_q <= w_count;
        b_count_q <= b_count;
        b_base_q  <= b_base;
        err       <= 1'b0;
        drain     <= 1'b0;
      end
      if (arm)       elem_cnt <= '0;
      else if (beat) elem_cnt <= elem_cnt + CNT_W'(LANES);
      if (beat_err) begin
        err   <= 1'b1;
        drain <= 1'b1;
      end
    end
  end

  axi_rd_burst_gen #(
    .ADDR_W    (ADDR_W),
    .BYTES     (BYTES),
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_burst_gen (
    .clk   (clk),
    .rst   (rst),
    .arm   (arm),
    .base  (arm_base),
    .total (arm_beats),
    .issue (issue),
    .addr  (gen_addr),
    .len   (gen_len),
    .more  (gen_more)
  );

  assign busy          = (state == ST_W_AR) || (state == ST_W_R) ||
                         (state == ST_B_AR) || (state == ST_B_R);
  assign done          = (state == ST_FIN);
  assign M_AXI_ARVALID = (state == ST_W_AR) || (state == ST_B_AR);
  assign M_AXI_ARADDR  = M_AXI_ARVALID ? gen_addr : '0;
  assign M_AXI_ARLEN   = M_AXI_ARVALID ? gen_len  : '0;
  assign M_AXI_ARSIZE  = 3'(SIZE_L2);
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_RREADY  = in_r;

  // A beat is written only while the burst is clean; an error beat and
  // everything after it in the same burst are dropped.
  assign sec_count = (state == ST_B_R) ? b_count_q : w_count_q;
  assign wr_en     = beat && !beat_err && !drain;
  assign wr_sel    = wr_en && (state == ST_B_R);
  assign wr_addr   = wr_en ? elem_cnt : '0;
  assign wr_data   = wr_en ? M_AXI_RDATA : '0;

  // Lanes beyond the section's element count are masked; only the final
  // beat of a section can be partial.
  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      wr_mask[k] = wr_en &&
                   (({1'b0, elem_cnt} + (CNT_W+1)'(k)) < {1'b0, sec_count});
    end
  end

endmodule

// File: tb/tb_axi_param_burst_loader.sv
// Self-checking bench: randomized-stall AXI slave model plus a reference
// model that derives expected AR bursts and element writes from the
// section base addresses and counts.
module tb_axi_param_burst_loader;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ELEM_W    = 8;
  localparam int MAX_BURST = 16;
  localparam int CNT_W     = 16;
  localparam int LANES     = DATA_W / ELEM_W;
  localparam int BYTES     = DATA_W / 8;

  logic              clk, rst, start;
  logic [ADDR_W-1:0] w_base, b_base;
  logic [CNT_W-1:0]  w_count, b_count;
  logic              busy, done, err;
  logic              M_AXI_ARVALID, M_AXI_ARREADY;
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [7:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic              M_AXI_RVALID, M_AXI_RREADY, M_AXI_RLAST;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              wr_en, wr_sel;
  logic [CNT_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LANES-1:0]  wr_mask;

  axi_param_burst_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ELEM_W(ELEM_W),
    .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .w_base(w_base), .w_count(w_count), .b_base(b_base), .b_count(b_count),
    .busy(busy), .done(done), .err(err),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic sel; logic [15:0] addr; logic [31:0] data; logic [3:0] mask; } wr_t;

  ar_t         exp_ar[$];
  wr_t         exp_wr[$];
  bit          exp_err;
  logic [31:0] seed;

  // Backing memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return seed ^ (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]};
  endfunction

  // Expected bursts and writes for one run; inj is the 0-based global beat
  // index that returns SLVERR (-1 for none).
  task automatic build_model(input logic [31:0] wb, input int wc,
                             input logic [31:0] bb, input int bc, input int inj);
    int          g;
    bit          stop;
    logic [31:0] base, a;
    int          cnt, beats, sent, n, room, idx;
    wr_t         w;
    g = 0; stop = 0;
    exp_ar.delete();
    exp_wr.delete();
    for (int s = 0; s < 2; s++) begin
      base  = (s != 0) ? bb : wb;
      cnt   = (s != 0) ? bc : wc;
      beats = (cnt + LANES - 1) / LANES;
      sent  = 0;
      while (sent < beats && !stop) begin
        a    = base + 32'(sent * BYTES);
        n    = beats - sent;
        if (n > MAX_BURST) n = MAX_BURST;
        room = (4096 - int'(a % 4096)) / BYTES;
        if (room < n) n = room;
        exp_ar.push_back('{addr: a, len: 8'(n - 1)});
        for (int i = 0; i < n; i++) begin
          if (g == inj) stop = 1;
          if (!stop) begin
            idx    = (sent + i) * LANES;
            w.sel  = (s != 0);
            w.addr = 16'(idx);
            w.data = mem_word(a + 32'(i * BYTES));
            for (int k = 0; k < LANES; k++) w.mask[k] = (idx + k < cnt);
            exp_wr.push_back(w);
          end
          g++;
        end
        sent += n;
      end
    end
    exp_err = stop;
  endtask

  // ---------------- AXI slave + monitor ----------------
  bit          start_req, stall_en, fin_poke;
  bit          hs_ar, hs_r, last_ar_wait;
  logic [31:0] last_araddr, s_addr;
  logic [7:0]  last_arlen;
  bit          s_active;
  int          s_len, s_idx, s_gbeat, s_inj, ar_wait, r_wait;
  int          ar_seen, wr_seen, done_cnt;

  function automatic int stall();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  task automatic step();
    ar_t e;
    wr_t w;
    @(negedge clk);
    if (rst) begin
      s_active = 0; hs_ar = 0; hs_r = 0; last_ar_wait = 0;
    end else begin
      if (hs_ar) begin
        ar_seen++;
        check("ar_expected", 64'(exp_ar.size() != 0), 1);
        if (exp_ar.size() != 0) begin
          e = exp_ar.pop_front();
          check("araddr", last_araddr, e.addr);
          check("arlen", last_arlen, e.len);
        end
        check("ar_4k", 64'((last_araddr % 4096) + (32'(last_arlen) + 1) * BYTES <= 4096), 1);
        s_active = 1; s_addr = last_araddr; s_len = int'(last_arlen); s_idx = 0;
        r_wait = stall(); ar_wait = stall();
      end else if (last_ar_wait) begin
        check("ar_hold_valid", M_AXI_ARVALID, 1);
        check("ar_hold_addr", M_AXI_ARADDR, last_araddr);
        check("ar_hold_len", M_AXI_ARLEN, last_arlen);
      end
      if (hs_r) begin
        if (M_AXI_RLAST) s_active = 0;
        s_idx++; s_gbeat++;
        r_wait = stall();
      end
    end
    start = start_req;
    start_req = 0;
    // read address channel
    M_AXI_ARREADY = 0;
    if (M_AXI_ARVALID && !rst) begin
      if (ar_wait == 0) M_AXI_ARREADY = 1;
      else ar_wait--;
    end
    // read data channel
    if (s_active && r_wait == 0) begin
      M_AXI_RVALID = 1;
      M_AXI_RDATA  = mem_word(s_addr + 32'(s_idx * BYTES));
      M_AXI_RLAST  = (s_idx == s_len);
      M_AXI_RRESP  = (s_gbeat == s_inj) ? 2'b10 : 2'b00;
    end else begin
      if (s_active) r_wait--;
      M_AXI_RVALID = 0;
      M_AXI_RLAST  = 0;
      M_AXI_RRESP  = 0;
      M_AXI_RDATA  = $urandom;
    end
    #1;
    hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
    hs_r  = M_AXI_RVALID && M_AXI_RREADY;
    last_ar_wait = M_AXI_ARVALID && !M_AXI_ARREADY;
    last_araddr  = M_AXI_ARADDR;
    last_arlen   = M_AXI_ARLEN;
    if (wr_en) begin
      wr_seen++;
      check("wr_expected", 64'(exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check("wr_sel", wr_sel, w.sel);
        check("wr_addr", wr_addr, w.addr);
        check("wr_data", wr_data, w.data);
        check("wr_mask", wr_mask, w.mask);
      end
    end
    if (done) begin
      done_cnt++;
      if (fin_poke) start = 1;   // must be ignored in FIN
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {busy, done, err, M_AXI_ARVALID, M_AXI_RREADY, wr_en, wr_sel, wr_mask}, 0);
    check({tag, "_ar"}, {M_AXI_ARADDR, M_AXI_ARLEN}, 0);
    check({tag, "_wr"}, {wr_addr, wr_data}, 0);
  endtask

  task automatic run(input logic [31:0] wb, input int wc, input logic [31:0] bb,
                     input int bc, input int inj, input bit stl, input int abort_ar,
                     output bit aborted);
    aborted = 0;
    build_model(wb, wc, bb, bc, inj);
    stall_en = stl; s_inj = inj; s_gbeat = 0; ar_wait = stall();
    done_cnt = 0; ar_seen = 0; wr_seen = 0;
    w_base = wb; w_count = 16'(wc); b_base = bb; b_count = 16'(bc);
    start_req = 1;
    step();
    step();
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
    // Config is latched: disturbing the inputs and re-requesting start mid-run
    // must have no effect.
    w_base = $urandom; w_count = 16'($urandom); b_base = $urandom; b_count = 16'($urandom);
    start_req = 1;
    for (int c = 0; c < 5000 && done_cnt == 0; c++) begin
      step();
      if (abort_ar != 0 && ar_seen == abort_ar && s_idx >= 3) begin
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      check("done_seen", done_cnt, 1);
      repeat (3) step();
      check("done_once", done_cnt, 1);
      check("idle_after_done", busy, 0);
      check("err_flag", err, exp_err);
      check("ar_left", exp_ar.size(), 0);
      check("wr_left", exp_wr.size(), 0);
    end
  endtask

  bit          ab;
  logic [31:0] rb_w, rb_b;

  initial begin
    rst = 1; start = 0; start_req = 0; fin_poke = 1; stall_en = 0;
    w_base = 0; w_count = 0; b_base = 0; b_count = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; M_AXI_RLAST = 0;
    s_active = 0; hs_ar = 0; hs_r = 0; last_ar_wait = 0; s_inj = -1;
    seed = $urandom;
    repeat (3) step();
    check_quiet("reset");
    rst = 0;
    step();
    check("arsize", M_AXI_ARSIZE, 2);
    check("arburst", M_AXI_ARBURST, 1);

    // 1: full layer, immediate-ready slave
    run(32'h0, 756, 32'h400, 28, -1, 0, 0, ab);
    check("s1_ar_count", ar_seen, 13);
    check("s1_wr_beats", wr_seen, 196);

    // 2: weights only, partial last beat
    run(32'h0, 10, 32'h800, 0, -1, 0, 0, ab);
    check("s2_ar_count", ar_seen, 1);

    // 3: 4 KB boundary split
    run(32'hFF8, 64, 32'h0, 0, -1, 0, 0, ab);
    check("s3_ar_count", ar_seen, 2);

    // 4: SLVERR on the 5th beat of the first weight burst
    run(32'h0, 756, 32'h400, 28, 4, 0, 0, ab);
    check("s4_ar_count", ar_seen, 1);
    check("s4_wr_beats", wr_seen, 4);
    check("s4_err_sticky", err, 1);

    // 5: random stalls, same layer as 1 (next start also clears err)
    run(32'h0, 756, 32'h400, 28, -1, 1, 0, ab);
    check("s5_wr_beats", wr_seen, 196);

    // random layers with stalls
    for (int i = 0; i < 3; i++) begin
      rb_w = $urandom; rb_w[1:0] = 2'b00;
      rb_b = $urandom; rb_b[1:0] = 2'b00;
      run(rb_w, int'($urandom_range(1, 300)), rb_b, int'($urandom_range(0, 40)), -1, 1, 0, ab);
    end

    // 6: reset in the middle of the 3rd weight burst, then a clean rerun
    run(32'h0, 756, 32'h400, 28, -1, 0, 3, ab);
    check("s6_aborted", ab, 1);
    rst = 1;
    step();
    check_quiet("mid_reset");
    step();
    rst = 0;
    step();
    run(32'h0, 756, 32'h400, 28, -1, 0, 0, ab);
    check("s6_wr_beats", wr_seen, 196);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
